// File: rtl/if_id_reg_pkg.sv
// Shared MIPS pipeline constants: exception codes, nop encoding and the
// instruction-memory address map used by the fetch and memory stages.
package mips_defs;

   localparam logic [4:0]  EXC_ADEL  = 5'd4;
   localparam logic [4:0]  EXC_ADES  = 5'd5;
   localparam logic [4:0]  EXC_NONE  = 5'd0;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] IM_BASE   = 32'h0000_3000;
   localparam int          IM_WORDS  = 4096;
   localparam logic [31:0] IM_LAST   = IM_BASE + 32'(4 * (IM_WORDS - 1));

   // Byte offset between a link instruction and its return address.
   localparam logic [31:0] LINK_OFFSET = 32'd8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc8;
      logic [31:0] instr;
      logic        valid;
      logic        bd;
      logic        exc;
      logic [4:0]  exccode;
   } if_id_slot_t;

   function automatic logic [31:0] link_addr(input logic [31:0] pc);
      return pc + LINK_OFFSET;
   endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Word-aligned window check for a memory address; flags an address error
// when the access is misaligned or falls outside [BASE, BASE+4*(WORDS-1)].
module fetch_addr_check #(
   parameter logic [31:0] BASE  = 32'h0000_3000,
   parameter int          WORDS = 4096
) (
   input  logic [31:0] addr,
   output logic        adel
);

   localparam logic [31:0] LAST = BASE + 32'(4 * (WORDS - 1));

   logic misaligned;
   logic below;
   logic above;

   always_comb begin
      misaligned = (addr[1:0] != 2'b00);
      below      = (addr < BASE);
      above      = (addr > LAST);
      adel       = misaligned | below | above;
   end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: latches PC, instruction and PC+8, tracks the
// delay-slot and valid bits, and turns fetch address errors into a tagged nop.
module if_id_reg
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC_P = mips_defs::RESET_PC,
   parameter logic [31:0] IM_BASE_P  = mips_defs::IM_BASE,
   parameter int          IM_WORDS_P = mips_defs::IM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        flush,
   input  logic [31:0] pc_f,
   input  logic [31:0] instr_f,
   input  logic        is_branch_d,
   output logic [31:0] pc_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        bd_d,
   output logic        exc_d,
   output logic [4:0]  exccode_d
);

   logic        adel_f;
   if_id_slot_t slot_q;
   if_id_slot_t load_slot;

   fetch_addr_check #(
      .BASE  (IM_BASE_P),
      .WORDS (IM_WORDS_P)
   ) u_fetch_addr_check (
      .addr (pc_f),
      .adel (adel_f)
   );

   // Memory data is never forwarded for a faulting fetch.
   always_comb begin
      load_slot.pc      = pc_f;
      load_slot.pc8     = link_addr(pc_f);
      load_slot.valid   = 1'b1;
      load_slot.bd      = is_branch_d;
      load_slot.exc     = adel_f;
      load_slot.exccode = adel_f ? EXC_ADEL : EXC_NONE;
      load_slot.instr   = adel_f ? INSTR_NOP : instr_f;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q.pc      <= RESET_PC_P;
         slot_q.pc8     <= link_addr(RESET_PC_P);
         slot_q.instr   <= INSTR_NOP;
         slot_q.valid   <= 1'b0;
         slot_q.bd      <= 1'b0;
         slot_q.exc     <= 1'b0;
         slot_q.exccode <= EXC_NONE;
      end else if (flush) begin
         // Keep a meaningful PC so EPC capture downstream stays sensible.
         slot_q.pc      <= pc_f;
         slot_q.pc8     <= link_addr(pc_f);
         slot_q.instr   <= INSTR_NOP;
         slot_q.valid   <= 1'b0;
         slot_q.bd      <= 1'b0;
         slot_q.exc     <= 1'b0;
         slot_q.exccode <= EXC_NONE;
      end else if (en) begin
         slot_q <= load_slot;
      end
   end

   assign pc_d      = slot_q.pc;
   assign pc8_d     = slot_q.pc8;
   assign instr_d   = slot_q.instr;
   assign valid_d   = slot_q.valid;
   assign bd_d      = slot_q.bd;
   assign exc_d     = slot_q.exc;
   assign exccode_d = slot_q.exccode;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, loads, stall/flush priority,
// address-error edges and reset during a stall.
module tb_if_id_reg;

   logic        clk;
   logic        reset;
   logic        en;
   logic        flush;
   logic [31:0] pc_f;
   logic [31:0] instr_f;
   logic        is_branch_d;
   logic [31:0] pc_d;
   logic [31:0] instr_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        bd_d;
   logic        exc_d;
   logic [4:0]  exccode_d;

   int tests_run;
   int tests_failed;

   if_id_reg dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .flush       (flush),
      .pc_f        (pc_f),
      .instr_f     (instr_f),
      .is_branch_d (is_branch_d),
      .pc_d        (pc_d),
      .instr_d     (instr_d),
      .pc8_d       (pc8_d),
      .valid_d     (valid_d),
      .bd_d        (bd_d),
      .exc_d       (exc_d),
      .exccode_d   (exccode_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slot packed as {pc, pc8, instr, valid, bd, exc, exccode}.
   function automatic logic [103:0] obs();
      return {pc_d, pc8_d, instr_d, valid_d, bd_d, exc_d, exccode_d};
   endfunction

   function automatic logic [103:0] mk(input logic [31:0] pc, input logic [31:0] pc8,
                                       input logic [31:0] instr, input logic v,
                                       input logic bd, input logic exc,
                                       input logic [4:0] code);
      return {pc, pc8, instr, v, bd, exc, code};
   endfunction

   // Apply inputs at the falling edge, then settle just after the rising edge.
   task automatic cycle(input logic r, input logic e, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic br);
      @(negedge clk);
      reset       = r;
      en          = e;
      flush       = f;
      pc_f        = pc;
      instr_f     = ins;
      is_branch_d = br;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [103:0] exp;
      cycle(1'b1, 1'b1, 1'b0, 32'h0000_3ABC, 32'hDEAD_BEEF, 1'b1);
      exp = mk(32'h0000_3000, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL reset_values: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_normal_load();
      logic [103:0] exp;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h3C01_1234, 1'b0);
      exp = mk(32'h0000_3004, 32'h0000_300C, 32'h3C01_1234, 1'b1, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL normal_load: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_delay_slot_stall_flush();
      logic [103:0] exp;
      logic [31:0]  pcs [3];
      pcs[0] = 32'h0000_3010;
      pcs[1] = 32'h0000_0001;
      pcs[2] = 32'h0000_7000;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h2108_0001, 1'b1);
      exp = mk(32'h0000_3008, 32'h0000_3010, 32'h2108_0001, 1'b1, 1'b1, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL delay_slot_load: got %h expected %h", obs(), exp);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 1'b0, pcs[i], 32'hA5A5_0000 + 32'(i), 1'b0);
         tests_run++;
         if (obs() !== exp) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: got %h expected %h", i, obs(), exp);
         end
      end
      cycle(1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'h1234_5678, 1'b1);
      exp = mk(32'h0000_3100, 32'h0000_3108, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL flush_over_stall: got %h expected %h", obs(), exp);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0000_3200, 32'h1111_1111, 1'b1);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL flush_then_hold: got %h expected %h", obs(), exp);
      end
      // Flush with a faulting pc_f must not raise exc.
      cycle(1'b0, 1'b1, 1'b1, 32'h0000_3002, 32'hFFFF_FFFF, 1'b1);
      exp = mk(32'h0000_3002, 32'h0000_300A, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL flush_over_load: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_misaligned();
      logic [103:0] exp;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3002, 32'hFFFF_FFFF, 1'b0);
      exp = mk(32'h0000_3002, 32'h0000_300A, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL misaligned: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_range_edges();
      logic [31:0]  pcs  [6];
      logic [31:0]  pc8s [6];
      logic         excs [6];
      logic [31:0]  ins;
      logic [103:0] exp;
      pcs[0] = 32'h0000_6FFC; pc8s[0] = 32'h0000_7004; excs[0] = 1'b0;
      pcs[1] = 32'h0000_7000; pc8s[1] = 32'h0000_7008; excs[1] = 1'b1;
      pcs[2] = 32'h0000_2FFC; pc8s[2] = 32'h0000_3004; excs[2] = 1'b1;
      pcs[3] = 32'hFFFF_FFFC; pc8s[3] = 32'h0000_0004; excs[3] = 1'b1;
      pcs[4] = 32'h0000_3000; pc8s[4] = 32'h0000_3008; excs[4] = 1'b0;
      pcs[5] = 32'h0000_6FFD; pc8s[5] = 32'h0000_7005; excs[5] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ins = 32'h8C00_0000 | 32'(i);
         cycle(1'b0, 1'b1, 1'b0, pcs[i], ins, i[0]);
         exp = mk(pcs[i], pc8s[i], excs[i] ? 32'h0 : ins, 1'b1, i[0], excs[i],
                  excs[i] ? 5'd4 : 5'd0);
         tests_run++;
         if (obs() !== exp) begin
            tests_failed++;
            $display("FAIL range_edge_%h: got %h expected %h", pcs[i], obs(), exp);
         end
      end
   endtask

   task automatic test_stall_illegal();
      logic [103:0] exp;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3020, 32'h0000_0020, 1'b0);
      exp = mk(32'h0000_3020, 32'h0000_3028, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0000_3021, 32'hFFFF_FFFF, 1'b1);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL stall_illegal_hold: got %h expected %h", obs(), exp);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3021, 32'hFFFF_FFFF, 1'b1);
      exp = mk(32'h0000_3021, 32'h0000_3029, 32'h0, 1'b1, 1'b1, 1'b1, 5'd4);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL stall_illegal_release: got %h expected %h", obs(), exp);
      end
      // Held exception slot keeps exc and bd through a stall.
      cycle(1'b0, 1'b0, 1'b0, 32'h0000_3030, 32'h0000_0030, 1'b0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL stall_exc_hold: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_back_to_back();
      logic [103:0] exp;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_7004, 32'hCAFE_0001, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3040, 32'hCAFE_0002, 1'b0);
      exp = mk(32'h0000_3040, 32'h0000_3048, 32'hCAFE_0002, 1'b1, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL back_to_back_clear: got %h expected %h", obs(), exp);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3044, 32'hCAFE_0003, 1'b1);
      exp = mk(32'h0000_3044, 32'h0000_304C, 32'hCAFE_0003, 1'b1, 1'b1, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL back_to_back_next: got %h expected %h", obs(), exp);
      end
   endtask

   task automatic test_reset_mid_stall();
      logic [103:0] exp;
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'h0BAD_F00D, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h0000_3050, 32'h5555_5555, 1'b0);
      exp = mk(32'h0000_3000, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL reset_mid_stall: got %h expected %h", obs(), exp);
      end
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_3002, 32'h6666_6666, 1'b1);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL reset_over_flush: got %h expected %h", obs(), exp);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h2402_000A, 1'b0);
      exp = mk(32'h0000_3000, 32'h0000_3008, 32'h2402_000A, 1'b1, 1'b0, 1'b0, 5'd0);
      tests_run++;
      if (obs() !== exp) begin
         tests_failed++;
         $display("FAIL load_after_reset: got %h expected %h", obs(), exp);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      en           = 1'b0;
      flush        = 1'b0;
      pc_f         = 32'h0;
      instr_f      = 32'h0;
      is_branch_d  = 1'b0;
      test_reset();
      test_normal_load();
      test_delay_slot_stall_flush();
      test_misaligned();
      test_range_edges();
      test_stall_illegal();
      test_back_to_back();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the fetch stage (PC register plus instruction memory) and the decode stage of the 5-stage MIPS pipeline.
- Latches the fetched PC and instruction, and computes PC+8 for link instructions.
- Tracks branch-delay-slot status and a valid bit.
- Detects fetch address errors (AdEL). On an error it injects a nop carrying an exception code, so the CP0 logic downstream can handle it precisely.

Parameters:
- RESET_PC, 32'h00003000, value presented on pc_d after reset; must equal the PC register reset value.
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; last legal address is IM_BASE + 4*(IM_WORDS-1) = 32'h00006FFC.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  load enable; 0 = stall (hold), driven by the same stall signal as the PC register.
- flush  input  1  discard the incoming slot; used on exception entry and eret.
- pc_f  input  32  fetch-stage PC (PC register output).
- instr_f  input  32  instruction memory read data for pc_f.
- is_branch_d  input  1  decode stage currently holds a branch or jump; marks the next loaded instruction as a delay slot.
- pc_d  output  32  latched PC.
- instr_d  output  32  latched instruction (32'h0 = nop when killed).
- pc8_d  output  32  pc_d + 8, registered rather than derived combinationally from pc_d.
- valid_d  output  1  slot holds a real fetched instruction.
- bd_d  output  1  latched instruction sits in a branch delay slot.
- exc_d  output  1  fetch exception pending on this slot.
- exccode_d  output  5  exception code; 5'd4 (AdEL) when exc_d is set, else 0.

Behaviour:
- Update priority at each posedge clk: reset > flush > (en==0 hold) > load.
- Reset: pc_d=RESET_PC, pc8_d=RESET_PC+8, instr_d=0, valid_d=0, bd_d=0, exc_d=0, exccode_d=0.
- Flush: instr_d=0, valid_d=0, bd_d=0, exc_d=0, exccode_d=0.
  - pc_d and pc8_d load pc_f and pc_f+8, so CP0 EPC logic still sees a sensible PC.
  - Flush overrides a simultaneous stall; the flushed slot does not persist.
- Hold (en=0, no flush, no reset): every output keeps its value, including bd_d and exc_d. is_branch_d is ignored.
- Load (en=1): pc_d=pc_f, pc8_d=pc_f+8 (32-bit add, wraps modulo 2^32), valid_d=1, bd_d=is_branch_d.
  - Address error: pc_f[1:0]!=0, pc_f<IM_BASE, or pc_f>last legal address. Then exc_d=1, exccode_d=5'd4 and instr_d=0; the memory data is never forwarded.
  - Otherwise: exc_d=0, exccode_d=0, instr_d=instr_f.
- Address-error detection is purely combinational on pc_f and costs no extra cycle. Load latency is 1 cycle from fetch to decode.
- An illegal pc_f arriving during a stall has no effect until en=1.
- Reset asserted during a stall or a flush still produces the reset values.
- Back-to-back loads: each cycle replaces the slot completely. No field is sticky across loads.
- All outputs come straight from registers; there is no combinational path from any input to any output.

Decomposition:
- Shared package mips_defs:
  - EXC_ADEL = 5'd4
  - INSTR_NOP = 32'h00000000
  - RESET_PC = 32'h00003000
  - IM_BASE and IM_LAST address constants
- Sub-module fetch_addr_check (combinational): inputs pc_f, IM_BASE, IM_WORDS; output adel.
  - The same checker will later be reused for the data-side AdEL/AdES checks in the memory stage.

Test Plan:
- Reset then idle: assert reset one cycle with en=1 → pc_d=32'h00003000, pc8_d=32'h00003008, instr_d=0, valid_d=0, exc_d=0.
- Normal load: pc_f=32'h00003004, instr_f=32'h3C011234, en=1 → next cycle pc_d=32'h00003004, pc8_d=32'h0000300C, instr_d=32'h3C011234, valid_d=1, bd_d=0.
- Delay slot, stall, flush priority:
  - Load with is_branch_d=1 → bd_d=1.
  - Then en=0 for 3 cycles with changing pc_f/instr_f and is_branch_d=0 → all outputs unchanged.
  - Then en=0 with flush=1 → instr_d=0, valid_d=0, bd_d=0.
- Misaligned fetch: pc_f=32'h00003002, instr_f=32'hFFFFFFFF, en=1 → instr_d=0, exc_d=1, exccode_d=4, valid_d=1, pc_d=32'h00003002.
- Range edges:
  - pc_f=32'h00006FFC → exc_d=0.
  - pc_f=32'h00007000 → exc_d=1, exccode_d=4.
  - pc_f=32'h00002FFC → exc_d=1.
  - pc_f=32'hFFFFFFFC → pc8_d=32'h00000004 (wrap), exc_d=1.
- Reset mid-stall: en=0 with a held valid slot, assert reset → reset values next cycle; deassert reset with en=1 and pc_f=32'h00003000 → normal load.
